// File: rtl/mips_cpu_muldiv_iter.sv
// -----------------------------------------------------------------------------
// mips_cpu_muldiv_iter
//   Iterative HI/LO multiply/divide unit for the MIPS core, plus the MFHI/MFLO
//   read responder. Multiply is shift-add and divide is restoring, one bit per
//   cycle over 32 CALC cycles. A final FIX cycle applies the MIPS sign rules
//   (quotient truncates toward zero, remainder takes the dividend's sign) and
//   writes HI/LO.
//
//   Optional build macro: MULDIV_EARLY_TERM_EN
//     defined   - multiply leaves CALC once the remaining multiplier bits are
//                 all zero (minimum 1 CALC cycle). Divide is unchanged.
//     undefined - every arithmetic op spends exactly 32 cycles in CALC.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   synchronous, active-high reset
//   start     in   issue strobe; op/a/b sampled when start=1 and busy=0
//   op[2:0]   in   000 DIVU, 001 MULTU, 010 DIV, 011 MULT, 100 MTHI,
//                  101 MTLO, 11x no-op
//   a[31:0]   in   rs operand (dividend / multiplicand / MTHI-MTLO data)
//   b[31:0]   in   rt operand (divisor / multiplier)
//   busy      out  high while an arithmetic op is in flight
//   rd_req    in   MFHI/MFLO request
//   rd_sel    in   0 = LO, 1 = HI
//   rd_data   out  selected HI/LO; forced to 0 while busy
//   rd_stall  out  rd_req & busy
// -----------------------------------------------------------------------------
module mips_cpu_muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    input  logic             rd_req,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_stall
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [4:0]  r_count;
    logic        r_is_mul;
    logic        r_sa;
    logic        r_sb;
    logic        r_b_zero;
    logic [31:0] r_a_raw;

    // multiply datapath
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic [63:0] r_prod;

    // divide datapath: r_quo starts as the dividend magnitude and the
    // quotient bits shift in from the bottom as dividend bits shift out
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvsr;

    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic        w_qbit;
    logic [31:0] w_rem_next;
    logic [63:0] w_prod_next;
    logic        w_last;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    // Sign flags only exist for the signed ops (op[1]=1). Negation wraps in
    // 32 bits, so 0x80000000 stays 0x80000000 and is read as magnitude 2^31.
    assign w_a_neg = op[1] & a[31];
    assign w_b_neg = op[1] & b[31];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    // Restoring step. The partial remainder stays below the divisor, so the
    // shifted value fits 33 bits and the trial's bit 32 is the borrow.
    assign w_shift    = {r_rem, r_quo[31]};
    assign w_trial    = w_shift - {1'b0, r_dvsr};
    assign w_qbit     = ~w_trial[32];
    assign w_rem_next = w_qbit ? w_trial[31:0] : w_shift[31:0];

    assign w_prod_next = r_mplier[0] ? (r_prod + r_mcand) : r_prod;

`ifdef MULDIV_EARLY_TERM_EN
    // Once the multiplier bits still to be consumed are zero, no further
    // add can change the product.
    assign w_last = (r_count == 5'd31) | (r_is_mul & ~|r_mplier[31:1]);
`else
    assign w_last = (r_count == 5'd31);
`endif

    assign w_prod_fix = (r_sa ^ r_sb) ? -r_prod : r_prod;
    assign w_quo_fix  = (r_sa ^ r_sb) ? -r_quo  : r_quo;
    assign w_rem_fix  = r_sa ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_hi     <= '0;
            r_lo     <= '0;
            r_count  <= '0;
            r_is_mul <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_b_zero <= 1'b0;
            r_a_raw  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (!op[2]) begin
                            r_is_mul <= op[0];
                            r_sa     <= w_a_neg;
                            r_sb     <= w_b_neg;
                            r_b_zero <= ~|b;
                            r_a_raw  <= a;
                            r_mcand  <= {32'd0, w_a_mag};
                            r_mplier <= w_b_mag;
                            r_prod   <= '0;
                            r_rem    <= '0;
                            r_quo    <= w_a_mag;
                            r_dvsr   <= w_b_mag;
                            r_count  <= '0;
                            r_state  <= S_CALC;
                        end else if (op == 3'b100) begin
                            r_hi <= a;
                        end else if (op == 3'b101) begin
                            r_lo <= a;
                        end
                    end
                end
                S_CALC: begin
                    if (r_is_mul) begin
                        r_prod   <= w_prod_next;
                        r_mcand  <= {r_mcand[62:0], 1'b0};
                        r_mplier <= {1'b0, r_mplier[31:1]};
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= {r_quo[30:0], w_qbit};
                    end
                    r_count <= r_count + 5'd1;
                    if (w_last) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_is_mul) begin
                        r_hi <= w_prod_fix[63:32];
                        r_lo <= w_prod_fix[31:0];
                    end else if (r_b_zero) begin
                        // divide by zero: raw dividend, no sign fix
                        r_hi <= r_a_raw;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign rd_stall = rd_req & busy;
    assign rd_data  = busy ? '0 : (rd_sel ? r_hi : r_lo);

endmodule

// File: tb/tb_mips_cpu_muldiv_iter.sv
// -----------------------------------------------------------------------------
// tb_mips_cpu_muldiv_iter
//   Directed bench for mips_cpu_muldiv_iter. Stimulus pushes the expected
//   MFHI/MFLO values into a queue; a monitor on the falling edge pops and
//   compares whenever a read is presented with busy low, and checks the stall
//   response whenever a read is presented with busy high.
//   Latency is counted in edges from the accepting edge through the edge that
//   writes HI/LO, both inclusive.
// -----------------------------------------------------------------------------
module tb_mips_cpu_muldiv_iter;

`ifdef MULDIV_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        rd_req;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        rd_stall;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    string       cur_tag = "reset";

    always #5 clk = ~clk;

    mips_cpu_muldiv_iter #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .rd_req   (rd_req),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .rd_stall (rd_stall)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got 0x%08h expected 0x%08h", cur_tag, name, act, exp);
        end
    endfunction

    // Monitor: reads are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!reset && rd_req) begin
            if (busy) begin
                check("rd_stall_busy", 32'(rd_stall), 32'd1);
                check("rd_data_busy", rd_data, 32'd0);
            end else begin
                check("rd_stall_idle", 32'(rd_stall), 32'd0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s/unexpected_read: got 0x%08h expected no read", cur_tag, rd_data);
                end else begin
                    check("rd_data", rd_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_pair(input logic [31:0] ehi, input logic [31:0] elo);
        exp_q.push_back(ehi);
        rd_req = 1'b1;
        rd_sel = 1'b1;
        tick();
        exp_q.push_back(elo);
        rd_sel = 1'b0;
        tick();
        rd_req = 1'b0;
    endtask

    // Waits for busy to drop; n enters as edges counted so far.
    task automatic wait_done(inout int n);
        while (busy && n <= 40) begin
            tick();
            n++;
        end
        if (busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s/busy_timeout: got busy=1 expected busy=0 within 40 edges", cur_tag);
        end
    endtask

    task automatic check_latency(input int n, input int lat, input bit exact);
        if (exact) check("latency", 32'(n), 32'(lat));
        else       check("latency_max", 32'(n <= lat), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int lat, input bit exact);
        int n;
        cur_tag = tag;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        n = 1;
        wait_done(n);
        check_latency(n, lat, exact);
        read_pair(ehi, elo);
    endtask

    initial begin
        int n;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'b111;
        a      = '0;
        b      = '0;
        rd_req = 1'b0;
        rd_sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("busy_reset", 32'(busy), 32'd0);
        check("stall_reset", 32'(rd_stall), 32'd0);
        read_pair(32'h0, 32'h0);

        // no-op encoding changes nothing
        cur_tag = "noop";
        start = 1'b1; op = 3'b110; a = 32'hDEADBEEF;
        tick();
        start = 1'b0;
        check("busy_noop", 32'(busy), 32'd0);
        read_pair(32'h0, 32'h0);

        run_op("mult_m2x3",   3'b011, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 34, !EARLY);
        run_op("multu_max",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34, !EARLY);
        run_op("div_m7d2",    3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34, 1'b1);
        run_op("divu_7d2",    3'b000, 32'd7,        32'd2,        32'd1,        32'd3,        34, 1'b1);
        run_op("divu_by0",    3'b000, 32'd10,       32'd0,        32'h0000000A, 32'hFFFFFFFF, 34, 1'b1);
        run_op("div_by0",     3'b010, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 34, 1'b1);
        run_op("div_ovf",     3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, 1'b1);
        run_op("div_7dm2",    3'b010, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34, 1'b1);
        run_op("mult_minsq",  3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 34, !EARLY);
        run_op("multu_5x3",   3'b001, 32'd5,        32'd3,        32'h0,        32'd15,       EARLY ? 6 : 34, !EARLY);

        // read held across a MULT: stalls while busy, second start ignored
        cur_tag = "stall_read";
        start = 1'b1; op = 3'b011; a = 32'hFFFFFFFE; b = 32'd3;
        tick();
        start = 1'b0;
        exp_q.push_back(32'hFFFFFFFF);
        rd_req = 1'b1;
        rd_sel = 1'b1;
        n = 1;
        while (busy && n <= 40) begin
            if (n == 5) begin
                start = 1'b1; op = 3'b001; a = '1; b = '1;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        wait_done(n);
        check_latency(n, 34, !EARLY);
        tick();
        rd_req = 1'b0;
        check("second_start_ignored", 32'(busy), 32'd0);
        read_pair(32'hFFFFFFFF, 32'hFFFFFFFA);

        // MTHI while busy is dropped
        cur_tag = "mthi_busy";
        start = 1'b1; op = 3'b001; a = 32'd2; b = 32'd3;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; op = 3'b100; a = 32'h0000DEAD;
        tick();
        start = 1'b0;
        n = 3;
        wait_done(n);
        read_pair(32'h0, 32'd6);

        // reset in the middle of CALC abandons the op and clears HI/LO
        cur_tag = "reset_mid";
        start = 1'b1; op = 3'b011; a = 32'd3; b = 32'h7FFFFFFF;
        tick();
        start = 1'b0;
        repeat (11) tick();
        check("busy_before_reset", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("busy_after_reset", 32'(busy), 32'd0);
        read_pair(32'h0, 32'h0);

        // MTLO/MTHI: same-cycle read sees the old value, write lands at the edge
        cur_tag = "mtlo";
        rd_req = 1'b1; rd_sel = 1'b0;
        start = 1'b1; op = 3'b101; a = 32'h12345678;
        exp_q.push_back(32'h0);
        tick();
        start = 1'b0;
        exp_q.push_back(32'h12345678);
        tick();
        cur_tag = "mthi";
        rd_sel = 1'b1;
        start = 1'b1; op = 3'b100; a = 32'h9ABCDEF0;
        exp_q.push_back(32'h0);
        tick();
        start = 1'b0;
        exp_q.push_back(32'h9ABCDEF0);
        tick();
        rd_req = 1'b0;
        read_pair(32'h9ABCDEF0, 32'h12345678);

        cur_tag = "end";
        repeat (2) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_cpu_muldiv_iter.md
Name: mips_cpu_muldiv_iter

Overview:
Iterative, multi-cycle HI/LO multiply/divide unit for the MIPS core. It replaces single-cycle combinational mult/div with a start/busy handshake toward the issue stage. It also provides the read-side (MFHI/MFLO) responder, which stalls the pipeline until HI/LO hold a finished result. Signed ops follow MIPS semantics exactly: quotient truncates toward zero, and the remainder takes the sign of the dividend.

Parameters:
WIDTH, 32, operand width; only 32 is supported, present for lint/readability.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  issue strobe; op/a/b sampled on the edge where start=1 and busy=0
op  input  3  000 DIVU, 001 MULTU, 010 DIV, 011 MULT, 100 MTHI, 101 MTLO, 11x no-op
a  input  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
b  input  32  rt operand (divisor / multiplier)
busy  output  1  high while an arithmetic op is in flight
rd_req  input  1  MFHI/MFLO request from decode
rd_sel  input  1  0 = LO, 1 = HI
rd_data  output  32  selected register, combinational from HI/LO
rd_stall  output  1  rd_req & busy; pipeline must hold the MF instruction

Behaviour:
- Reset: state=IDLE, HI=LO=0, busy=0, rd_stall=0, rd_data=0. Reset wins over every other input, including mid-operation: the op is abandoned and HI/LO are cleared.
- State machine:
  - IDLE
    - start & op in {000..011}: latch operands and sign flags, load magnitudes (unsigned ops use raw values), count=0, go to CALC.
    - start & op=100: HI<=a, stay in IDLE.
    - start & op=101: LO<=a, stay in IDLE.
    - op 11x: no state change.
  - CALC
    - One iteration per cycle, 32 cycles (count 0..31), then go to FIX.
    - Multiply: shift-add. 64-bit product accumulator; multiplier shifts right 1 per cycle.
    - Divide: restoring. 33-bit partial remainder; shift the quotient bit in each cycle.
  - FIX
    - Apply sign correction and write HI/LO, then go to IDLE.
    - MULT: negate the 64-bit product if sa^sb.
    - DIV: negate the quotient if sa^sb; negate the remainder if sa.
    - Mult ops: HI=product[63:32], LO=product[31:0]. Div ops: LO=quotient, HI=remainder.
- busy: goes high on the edge after the accepted start, and stays high through CALC and FIX. It drops on the edge on which HI/LO are written. Arithmetic latency is 34 cycles from the accepting edge to the HI/LO update.
- start while busy: ignored. No queuing, and operands are not resampled.
- MTHI/MTLO while busy: ignored; issue must stall on busy.
- Divide by zero, both DIV and DIVU: LO=0xFFFFFFFF, HI=a (the raw dividend). No sign fix, no trap.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of 32-bit wrap on the magnitude negation.
- Reads:
  - rd_data = rd_sel ? HI : LO whenever busy=0; rd_data=0 while busy.
  - A read in the same cycle as an MTHI/MTLO write returns the old value; the write lands at the edge.

Optional Feature:
MULDIV_EARLY_TERM_EN:
- Defined: multiply ops leave CALC as soon as the remaining multiplier bits are all zero, with a minimum of 1 CALC cycle. The product is bit-identical to the full run. Divide is unaffected.
- Undefined: every arithmetic op takes exactly 32 CALC cycles, giving a fixed 34-cycle latency.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 -> busy for 34 cycles (macro off), then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU a=7, b=2 -> LO=3, HI=1.
- DIVU a=10, b=0 -> LO=0xFFFFFFFF, HI=0x0000000A.
- rd_req=1, rd_sel=1 asserted during a MULT -> rd_stall=1 every busy cycle. On the first cycle with busy=0, rd_stall=0 and rd_data equals the new HI. A second start at cycle 5 is ignored.
- Reset at CALC cycle 10 -> next cycle busy=0 and HI=LO=0. A following MTLO a=0x12345678 gives LO=0x12345678 one edge later. With MULDIV_EARLY_TERM_EN, MULTU 5*3 gives busy for ≤5 cycles and LO=15.
